// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit result holding slots arbitrated onto one registered CDB.
// Fixed priority by default; define CDB_ARB_RR_EN for round-robin.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   flush       drop every pending result, block transfers and grants
//   req_valid   per-unit result valid
//   req_data    per-unit cdb_t payload (its valid field is ignored)
//   req_ready   per-unit accept (combinational)
//   cdb_out     registered broadcast; cdb_out.valid marks a live result
//   grant_idx   requester index of the payload in cdb_out
package rv32i_types;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rob_idx;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
  } cdb_t;
endpackage

module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  cdb_t [NUM_REQ-1:0]         req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output cdb_t                       cdb_out,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] r_slot_vld;
  cdb_t [NUM_REQ-1:0] r_slot;
  cdb_t               r_cdb;
  logic [IW-1:0]      r_gnt_idx;

  logic [IW:0]        w_pick;
  logic               w_gnt;
  logic [IW-1:0]      w_sel;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [NUM_REQ-1:0] w_xfer;
  cdb_t               w_bcast;

  // {found, index} of the lowest set bit
  function automatic logic [IW:0] f_pick(
    input logic [NUM_REQ-1:0] v
  );
    logic [IW:0] r;
    r = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (v[k]) r = {1'b1, IW'(k)};
    end
    return r;
  endfunction

`ifdef CDB_ARB_RR_EN
  logic [IW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] w_hi_mask;
  logic [IW:0]        w_pick_hi;
  logic [IW:0]        w_pick_all;

  // Search from r_ptr upward first, then wrap to the bottom.
  always_comb begin
    w_hi_mask = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_hi_mask[k] = (IW'(k) >= r_ptr);
    end
  end

  assign w_pick_hi  = f_pick(r_slot_vld & w_hi_mask);
  assign w_pick_all = f_pick(r_slot_vld);
  assign w_pick     = w_pick_hi[IW] ? w_pick_hi
                                    : w_pick_all;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_gnt) begin
      if (w_sel == IW'(NUM_REQ-1)) r_ptr <= '0;
      else                         r_ptr <= w_sel + IW'(1);
    end
  end
`else
  assign w_pick = f_pick(r_slot_vld);
`endif

  assign w_sel = w_pick[IW-1:0];
  assign w_gnt = w_pick[IW] & ~flush;

  always_comb begin
    w_gnt_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_gnt_oh[k] = w_gnt & (w_sel == IW'(k));
    end
  end

  // A slot being granted this cycle may refill at the same edge.
  assign req_ready = {NUM_REQ{rst_n & ~flush}}
                   & (~r_slot_vld | w_gnt_oh);
  assign w_xfer    = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_vld <= '0;
      r_slot     <= '0;
    end else if (flush) begin
      r_slot_vld <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_xfer[k]) begin
          r_slot_vld[k] <= 1'b1;
          r_slot[k]     <= req_data[k];
        end else if (w_gnt_oh[k]) begin
          r_slot_vld[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_bcast       = r_slot[w_sel];
    w_bcast.valid = 1'b1;
  end

  // Payload and index hold when idle; only valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb     <= '0;
      r_gnt_idx <= '0;
    end else if (w_gnt) begin
      r_cdb     <= w_bcast;
      r_gnt_idx <= w_sel;
    end else begin
      r_cdb.valid <= 1'b0;
    end
  end

  assign cdb_out   = r_cdb;
  assign grant_idx = r_gnt_idx;

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(w_gnt_oh));

  a_flush_kill: assert property (
    @(posedge clk) disable iff (!rst_n)
    flush |=> !cdb_out.valid);

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter.
// Build with or without CDB_ARB_RR_EN to match the DUT.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [N-1:0] req_valid;
  cdb_t [N-1:0] req_data;
  logic [N-1:0] req_ready;
  cdb_t         cdb_out;
  logic [2:0]   grant_idx;

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] rd_v;
    logic [4:0]  rob;
  } exp_t;

  exp_t q[$];

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_out   (cdb_out),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic cdb_t mk(input logic [31:0] v,
                              input logic [4:0] rob);
    cdb_t d;
    d         = '0;
    d.rd_v    = v;
    d.rob_idx = rob;
    d.rd_s    = rob;
    return d;
  endfunction

  task automatic push(input int c, input int idx,
                      input logic [31:0] v,
                      input logic [4:0] rob);
    exp_t e;
    e.cyc  = c;
    e.idx  = idx;
    e.rd_v = v;
    e.rob  = rob;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 32'(q.size()), 32'h0);
    q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n === 1'b1 && cdb_out.valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_bcast", 32'(cdb_out.valid), 32'h0);
      end else begin
        e = q.pop_front();
        chk("bcast_cyc", cyc, e.cyc);
        chk("bcast_idx", 32'(grant_idx), e.idx);
        chk("bcast_rd_v", cdb_out.rd_v, e.rd_v);
        chk("bcast_rob", 32'(cdb_out.rob_idx), 32'(e.rob));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int cnt[2];
    bit xf[2];

    rst_n     = 1'b1;
    flush     = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) req_data[i] = mk(32'h50 + 32'(i), 5'(i));
    #1 rst_n = 1'b0;
    mon_en = 1'b1;

    // reset held three cycles with all requesters valid
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_cdb_v", 32'(cdb_out.valid), 32'h0);
      chk("rst_rd_v", cdb_out.rd_v, 32'h0);
      chk("rst_gidx", 32'(grant_idx), 32'h0);
    end
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single uncontended result: N+2 latency
    tick;
    req_valid   = 5'b00100;
    req_data[2] = mk(32'h1234, 5'd7);
    push(cyc + 2, 2, 32'h1234, 5'd7);
    @(negedge clk);
    chk("single_ready", 32'(req_ready[2]), 32'h1);
    tick;
    req_valid = '0;
    drain("single_drain", 10);
    @(negedge clk);
    chk("hold_valid", 32'(cdb_out.valid), 32'h0);
    chk("hold_rd_v", cdb_out.rd_v, 32'h1234);
    chk("hold_gidx", 32'(grant_idx), 32'h2);

    // reset mid-operation discards a pending slot
    tick;
    req_valid   = 5'b01000;
    req_data[3] = mk(32'hDEAD, 5'd3);
    tick;
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    chk("midrst_cdb_v", 32'(cdb_out.valid), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // contention: all five in the first cycle after reset
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_data[i] = mk(32'hA000 + 32'(i), 5'(10 + i));
      push(cyc + 2 + i, i, 32'hA000 + 32'(i), 5'(10 + i));
    end
    @(negedge clk);
    chk("cont_ready", 32'(req_ready), 32'h1F);
    tick;
    req_valid = '0;
    drain("cont_drain", 12);

    // fairness: units 0 and 1 always requesting
    cnt[0] = 0;
    cnt[1] = 0;
    xf[0]  = 1'b0;
    xf[1]  = 1'b0;
    tick;
    c0 = cyc;
`ifdef CDB_ARB_RR_EN
    for (int n = 0; n < 9; n++) begin
      push(c0 + 2 + n, n % 2,
           ((n % 2 == 0) ? 32'h1000 : 32'h2000) + 32'(n / 2),
           5'(n % 2));
    end
`else
    for (int n = 0; n < 8; n++) begin
      push(c0 + 2 + n, 0, 32'h1000 + 32'(n), 5'd0);
    end
    push(c0 + 10, 1, 32'h2000, 5'd1);
`endif
    for (int t = 0; t < 8; t++) begin
      for (int u = 0; u < 2; u++) begin
        if (xf[u]) cnt[u]++;
      end
      req_valid   = 5'b00011;
      req_data[0] = mk(32'h1000 + 32'(cnt[0]), 5'd0);
      req_data[1] = mk(32'h2000 + 32'(cnt[1]), 5'd1);
      @(negedge clk);
      xf[0] = req_ready[0];
      xf[1] = req_ready[1];
      tick;
    end
    req_valid = '0;
    drain("fair_drain", 12);

    // flush with slots 1 and 3 pending
    req_valid   = 5'b01010;
    req_data[1] = mk(32'h1111, 5'd1);
    req_data[3] = mk(32'h3333, 5'd3);
    tick;
    flush     = 1'b1;
    req_valid = '1;
    @(negedge clk);
    chk("flush_ready", 32'(req_ready), 32'h0);
    tick;
    flush     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("flush_cdb_v1", 32'(cdb_out.valid), 32'h0);
    chk("flush_empty", 32'(req_ready), 32'h1F);
    tick;
    @(negedge clk);
    chk("flush_cdb_v2", 32'(cdb_out.valid), 32'h0);
    tick;

    // grant and refill slot 4 in the same cycle
    req_valid   = 5'b10000;
    req_data[4] = mk(32'hAAAA, 5'd4);
    push(cyc + 2, 4, 32'hAAAA, 5'd4);
    tick;
    req_data[4] = mk(32'hBEEF, 5'd5);
    push(cyc + 2, 4, 32'hBEEF, 5'd5);
    @(negedge clk);
    chk("refill_ready", 32'(req_ready[4]), 32'h1);
    tick;
    req_valid = '0;
    drain("refill_drain", 10);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 5, number of functional-unit requesters; index 0 = ALU, 1 = MUL, 2 = DIV, 3 = MEM, 4 = BRANCH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 flush  input  1  pipeline flush (branch mispredict); discards all pending results.
REQ-005 req_valid  input  NUM_REQ  per-unit result valid.
REQ-006 req_data  input  NUM_REQ x $bits(cdb_t)  per-unit result payload (rv32i_types cdb_t).
REQ-007 req_ready  output  NUM_REQ  per-unit accept; a transfer occurs when req_valid[i] & req_ready[i].
REQ-008 cdb_out  output  $bits(cdb_t)  registered broadcast payload; cdb_out.valid marks a live broadcast.
REQ-009 grant_idx  output  $clog2(NUM_REQ)  index of the requester broadcast in the current cdb_out.

Function
REQ-010 Block SHALL hold one holding slot per requester (valid bit plus cdb_t payload).
REQ-011 req_ready[i] SHALL equal !flush & (!slot_valid[i] | slot i granted this cycle), combinationally.
REQ-012 On transfer, slot i SHALL capture req_data[i] at the next edge; cdb_t.valid field of input is ignored.
REQ-013 Each cycle without flush, arbiter SHALL select at most one valid slot; the selected slot SHALL be cleared and its payload registered into cdb_out with valid=1 at the next edge.
REQ-014 If no slot is valid, cdb_out.valid SHALL be 0 next cycle; other cdb_out fields hold their previous value.
REQ-015 cdb_out.valid SHALL be high for exactly one cycle per granted result; one broadcast per cycle maximum.
REQ-016 Latency: transfer in cycle N, uncontended, SHALL produce cdb_out.valid in cycle N+2.
REQ-017 Simultaneous grant and refill of the same slot in one cycle SHALL broadcast the old payload and store the new one.
REQ-018 flush SHALL clear all slot_valid bits and cdb_out.valid at the next edge; no grant and no transfer occur in a flush cycle.
REQ-019 Priority pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-020 No result accepted into a slot SHALL be lost or duplicated except by flush.

Reset
REQ-021 While rst_n=0: all slot_valid=0, cdb_out=0 (including valid), grant_idx=0, priority pointer=0, req_ready=0.
REQ-022 Reset asserted mid-operation SHALL discard all pending slots immediately; first transfer possible in the first cycle after rst_n rises.

Configuration
REQ-023 Macro CDB_ARB_RR_EN defined: round-robin; search starts at pointer, pointer moves to granted index+1 after each grant; any valid slot waits at most NUM_REQ-1 grants.
REQ-024 CDB_ARB_RR_EN undefined: fixed priority, lowest index wins; pointer logic absent, starvation permitted.

Verification
REQ-025 Reset: hold rst_n=0 3 cycles with req_valid=5'b11111 -> req_ready=0, cdb_out.valid=0 throughout.
REQ-026 Single: req_valid[2]=1 (rd_v=0x1234, rob_idx=7) in cycle 10 -> cdb_out.valid=1, rd_v=0x1234, rob_idx=7, grant_idx=2 in cycle 12 only.
REQ-027 Contention (RR): all 5 slots valid, no new input -> grant_idx sequence 0,1,2,3,4 in five consecutive cycles, then cdb_out.valid=0; fixed-priority build gives same order.
REQ-028 Fairness (RR): units 0 and 1 refill every cycle -> grants alternate 0,1,0,1; unit 1 never waits more than 1 grant; fixed-priority build -> unit 0 granted every cycle, unit 1 starved.
REQ-029 Flush: slots 1,3 valid, flush=1 one cycle -> req_ready=0 that cycle, no cdb_out.valid the following two cycles, slots empty.
REQ-030 Grant-and-refill: slot 4 granted while req_valid[4]=1 with new rd_v=0xBEEF -> old payload broadcast next cycle, 0xBEEF broadcast on a later cycle, each exactly once.
